// File: rtl/byte_stripe_n.sv
// Round-robin byte striper with framing alignment: starts land in lane 0, ends in lane LANES-1.
// Optional macro BYTE_STRIPE_PAD_EN pads an early END/EDB out to the last lane instead of flagging it.
module byte_stripe_n #(
  parameter int          LANES   = 4,
  parameter int          BITS    = 8,
  parameter logic [7:0]  PAD_SYM = 8'h7c
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [BITS-1:0]       D,
  input  logic                  DK,
  input  logic                  VALID_IN,
  output logic [LANES*BITS-1:0] LANE_OUT,
  output logic [LANES-1:0]      DK_OUT,
  output logic                  VALID_OUT,
  output logic                  ERR
);

  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  typedef enum logic {IDLE, PACKET} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [LANES-1:0][BITS-1:0]  stage_sym_q, stage_sym_d;
  logic [LANES-1:0]            stage_dk_q, stage_dk_d;
  logic [LANES-1:0][BITS-1:0]  lane_q, grp_sym;
  logic [LANES-1:0]            dk_q, grp_dk;
  logic                        valid_q, err_q, emit, err_d;
  logic                        is_start, is_end;

  // Framing codes only count as such when flagged as control (DK=0).
  assign is_start = !DK && (D == BITS'(8'hfb) || D == BITS'(8'h5c));
  assign is_end   = !DK && (D == BITS'(8'hfd) || D == BITS'(8'hfe));

`ifdef BYTE_STRIPE_PAD_EN
  logic [LANES-1:0] pad_mask;
  for (genvar gi = 0; gi < LANES; gi++) begin : g_pad
    assign pad_mask[gi] = (IW'(gi) >= idx_q) && (gi < LANES - 1);
  end
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    stage_sym_d = stage_sym_q;
    stage_dk_d  = stage_dk_q;
    emit        = 1'b0;
    err_d       = 1'b0;
    // The emitted group is the staging file with the current symbol dropped into lane idx.
    grp_sym        = stage_sym_q;
    grp_dk         = stage_dk_q;
    grp_sym[idx_q] = D;
    grp_dk[idx_q]  = DK;
    if (VALID_IN) begin
      case (state_q)
        IDLE: begin
          if (is_start) begin
            stage_sym_d[0] = D;
            stage_dk_d[0]  = 1'b0;
            idx_d          = IW'(1);
            state_d        = PACKET;
          end else begin
            err_d = 1'b1;
          end
        end
        PACKET: begin
          if (DK) begin
            stage_sym_d[idx_q] = D;
            stage_dk_d[idx_q]  = 1'b1;
            if (idx_q == LAST) begin
              emit  = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else if (is_start) begin
            err_d          = 1'b1;
            stage_sym_d[0] = D;
            stage_dk_d[0]  = 1'b0;
            idx_d          = IW'(1);
          end else if (is_end) begin
            idx_d   = '0;
            state_d = IDLE;
            if (idx_q == LAST) begin
              emit = 1'b1;
            end else begin
`ifdef BYTE_STRIPE_PAD_EN
              for (int k = 0; k < LANES; k++) begin
                if (pad_mask[k]) begin
                  grp_sym[k] = BITS'(PAD_SYM);
                  grp_dk[k]  = 1'b0;
                end
              end
              grp_sym[LANES-1] = D;
              grp_dk[LANES-1]  = 1'b0;
              emit             = 1'b1;
`else
              err_d = 1'b1;
`endif
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      stage_sym_q <= '0;
      stage_dk_q  <= '0;
      lane_q      <= '0;
      dk_q        <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stage_sym_q <= stage_sym_d;
      stage_dk_q  <= stage_dk_d;
      valid_q     <= emit;
      err_q       <= err_d;
      if (emit) begin
        lane_q <= grp_sym;
        dk_q   <= grp_dk;
      end
    end
  end

  assign LANE_OUT  = lane_q;
  assign DK_OUT    = dk_q;
  assign VALID_OUT = valid_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_byte_stripe_n.sv
// Directed self-checking bench for byte_stripe_n (LANES=4, BITS=8).
module tb_byte_stripe_n;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  d = '0;
  logic        dk = 1'b0;
  logic        vin = 1'b0;
  logic [31:0] lane_out;
  logic [3:0]  dk_out;
  logic        vout, err;
  int checks = 0;
  int failures = 0;

  byte_stripe_n #(.LANES(4), .BITS(8), .PAD_SYM(8'h7c)) dut (
    .CLK(clk), .RESET(rst), .D(d), .DK(dk), .VALID_IN(vin),
    .LANE_OUT(lane_out), .DK_OUT(dk_out), .VALID_OUT(vout), .ERR(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [7:0] sd, input logic sdk, input logic sv);
    @(negedge clk);
    d = sd; dk = sdk; vin = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic sym(input string tag, input logic [7:0] sd, input logic sdk,
                     input logic ev, input logic ee);
    step(sd, sdk, 1'b1);
    $display("tb: %s D=%h DK=%b -> VALID_OUT=%b ERR=%b LANE_OUT=%h DK_OUT=%b",
             tag, sd, sdk, vout, err, lane_out, dk_out);
    chk({tag, "_valid"}, 32'(vout), 32'(ev));
    chk({tag, "_err"}, 32'(err), 32'(ee));
  endtask

  task automatic grp(input string tag, input logic [31:0] el, input logic [3:0] ed);
    chk({tag, "_lanes"}, lane_out, el);
    chk({tag, "_dk"}, 32'(dk_out), 32'(ed));
  endtask

  initial begin
    // Reset state
    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    grp("rst", 32'h0, 4'h0);
    chk("rst_valid", 32'(vout), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // 1. Reset mid-packet, with live input that reset must override
    @(negedge clk); rst = 1'b0;
    sym("t1_stp", 8'hfb, 1'b0, 1'b0, 1'b0);
    sym("t1_11", 8'h11, 1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    step(8'h22, 1'b1, 1'b1);
    step(8'hfd, 1'b0, 1'b1);
    grp("t1_rst", 32'h0, 4'h0);
    chk("t1_rst_valid", 32'(vout), 32'h0);
    chk("t1_rst_err", 32'(err), 32'h0);
    @(negedge clk); rst = 1'b0; vin = 1'b0;
    sym("t1_stp2", 8'hfb, 1'b0, 1'b0, 1'b0);
    sym("t1_a", 8'h11, 1'b1, 1'b0, 1'b0);
    sym("t1_b", 8'h22, 1'b1, 1'b0, 1'b0);
    sym("t1_end", 8'hfd, 1'b0, 1'b1, 1'b0);
    grp("t1", 32'hfd2211fb, 4'b0110);

    // 2. Basic packet, then pulse must drop and outputs hold
    sym("t2_stp", 8'hfb, 1'b0, 1'b0, 1'b0);
    sym("t2_a", 8'h11, 1'b1, 1'b0, 1'b0);
    sym("t2_b", 8'h22, 1'b1, 1'b0, 1'b0);
    sym("t2_end", 8'hfd, 1'b0, 1'b1, 1'b0);
    grp("t2", 32'hfd2211fb, 4'b0110);
    step(8'h00, 1'b0, 1'b0);
    chk("t2_drop", 32'(vout), 32'h0);
    grp("t2_hold", 32'hfd2211fb, 4'b0110);

    // 3. Back-to-back groups
    sym("t3_sdp", 8'h5c, 1'b0, 1'b0, 1'b0);
    sym("t3_01", 8'h01, 1'b1, 1'b0, 1'b0);
    sym("t3_02", 8'h02, 1'b1, 1'b0, 1'b0);
    sym("t3_03", 8'h03, 1'b1, 1'b1, 1'b0);
    grp("t3_g0", 32'h0302015c, 4'b1110);
    sym("t3_04", 8'h04, 1'b1, 1'b0, 1'b0);
    sym("t3_05", 8'h05, 1'b1, 1'b0, 1'b0);
    sym("t3_06", 8'h06, 1'b1, 1'b0, 1'b0);
    sym("t3_edb", 8'hfe, 1'b0, 1'b1, 1'b0);
    grp("t3_g1", 32'hfe060504, 4'b0111);

    // 4. Early END
    sym("t4_stp", 8'hfb, 1'b0, 1'b0, 1'b0);
    sym("t4_aa", 8'haa, 1'b1, 1'b0, 1'b0);
`ifdef BYTE_STRIPE_PAD_EN
    sym("t4_end", 8'hfd, 1'b0, 1'b1, 1'b0);
    grp("t4", 32'hfd7caafb, 4'b0010);
`else
    sym("t4_end", 8'hfd, 1'b0, 1'b0, 1'b1);
    grp("t4_hold", 32'hfe060504, 4'b0111);
    sym("t4_idle", 8'h44, 1'b1, 1'b0, 1'b1);
`endif

    // 5. Violations
    sym("t5_idle33", 8'h33, 1'b1, 1'b0, 1'b1);
    sym("t5_stp", 8'hfb, 1'b0, 1'b0, 1'b0);
    sym("t5_11", 8'h11, 1'b1, 1'b0, 1'b0);
    sym("t5_restart", 8'hfb, 1'b0, 1'b0, 1'b1);
    sym("t5_22", 8'h22, 1'b1, 1'b0, 1'b0);
    sym("t5_33", 8'h33, 1'b1, 1'b0, 1'b0);
    sym("t5_end", 8'hfd, 1'b0, 1'b1, 1'b0);
    grp("t5", 32'hfd3322fb, 4'b0110);

    // Framing values as data pass through; a stray control code is dropped
    sym("t7_stp", 8'hfb, 1'b0, 1'b0, 1'b0);
    sym("t7_fd", 8'hfd, 1'b1, 1'b0, 1'b0);
    sym("t7_idl", 8'h7c, 1'b0, 1'b0, 1'b1);
    sym("t7_5c", 8'h5c, 1'b1, 1'b0, 1'b0);
    sym("t7_end", 8'hfd, 1'b0, 1'b1, 1'b0);
    grp("t7", 32'hfd5cfdfb, 4'b0110);

    // 6. Gaps of three idle cycles between symbols
    begin
      logic [7:0] gs [4] = '{8'hfb, 8'h11, 8'h22, 8'hfd};
      logic       gk [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        sym($sformatf("t6_s%0d", i), gs[i], gk[i], (i == 3), 1'b0);
        for (int j = 0; j < 3; j++) begin
          step(8'hfd, 1'b0, 1'b0);
          chk($sformatf("t6_gap%0d_%0d_valid", i, j), 32'(vout), 32'h0);
          chk($sformatf("t6_gap%0d_%0d_err", i, j), 32'(err), 32'h0);
        end
      end
      grp("t6", 32'hfd2211fb, 4'b0110);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/byte_stripe_n.md
# byte_stripe_n

Parametrised byte striper for the multi-lane physical-layer transmit path. Accepts a serial byte stream with a per-byte K flag and distributes it across `LANES` lanes in round-robin order. Enforces framing alignment: a start symbol always lands in lane 0 and an end symbol always lands in lane `LANES-1`. Each complete lane group is presented in parallel to the per-lane scramblers with a one-cycle valid strobe.

## Interface
- `LANES`, default 4: lane count, 2..8.
- `BITS`, default 8: symbol width, ≥8. Framing codes are compared zero-extended.
- `PAD_SYM`, default 8'h7c (IDL): padding symbol used by the pad feature.
- `CLK` input 1: single clock, all logic on rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `D` input BITS: input symbol.
- `DK` input 1: 0 = framing/control symbol, 1 = data byte.
- `VALID_IN` input 1: `D`/`DK` valid this cycle. There is no backpressure; the block always accepts.
- `LANE_OUT` output LANES*BITS: lane k occupies bits [k*BITS +: BITS].
- `DK_OUT` output LANES: DK of lane k at bit k.
- `VALID_OUT` output 1: one-cycle pulse when `LANE_OUT`/`DK_OUT` carry a new group.
- `ERR` output 1: one-cycle pulse on a framing violation.

## Operation
- Framing codes: STP=fb, SDP=5c, END=fd, EDB=fe. These are valid only with DK=0.
- Internal state:
  - FSM {IDLE, PACKET}.
  - Lane index `idx`, 0..LANES-1.
  - Staging registers for each lane (symbol + DK).
- Only cycles with VALID_IN=1 act. Cycles with VALID_IN=0 change nothing and clear the pulses.
- IDLE:
  - STP/SDP (DK=0) → stage in lane 0, idx=1, go PACKET.
  - Any other accepted symbol → ERR, symbol dropped, idx stays 0.
- PACKET, data byte (DK=1, any value including framing code values):
  - Stage in lane idx.
  - If idx==LANES-1: emit the group and set idx=0. Otherwise idx+1.
- PACKET, END/EDB (DK=0):
  - idx==LANES-1 → stage, emit, idx=0, go IDLE.
  - idx<LANES-1 → see Configuration.
- PACKET, STP/SDP:
  - ERR pulse and partial group discarded.
  - The new start is staged in lane 0, idx=1, stay PACKET (packet restart).
- PACKET, DK=0 with a non-framing code (COM, SKP, IDL, …) → ERR, symbol dropped, idx unchanged.
- Emit:
  - Staged lanes plus the current symbol are copied to `LANE_OUT`/`DK_OUT`.
  - `VALID_OUT`=1 for one cycle.
  - Outputs hold their value until the next emit.
- Simultaneous ERR and emit cannot occur: each accepted symbol produces at most one of them.

## Timing
- Registered outputs. `VALID_OUT` and `ERR` assert in the cycle following the rising edge that accepts the causing symbol.
- Latency: last symbol of a group accepted at edge n → group visible after edge n (valid for cycle n+1).
- Back-to-back groups are supported: `VALID_OUT` may be high on consecutive cycles with no gap.
- Reset:
  - `RESET`=1 at an edge → FSM IDLE, idx=0, staging cleared.
  - `LANE_OUT`=0, `DK_OUT`=0, `VALID_OUT`=0, `ERR`=0.
  - Reset overrides any input the same cycle.
  - Reset mid-packet discards the partial group silently, with no ERR.
- Throughput: one symbol per cycle.

## Configuration
- Macro `BYTE_STRIPE_PAD_EN` controls early-END handling (END/EDB arriving with idx<LANES-1).
- Defined:
  - Lanes idx..LANES-2 are filled with `PAD_SYM`, DK=0.
  - END/EDB is placed in lane LANES-1.
  - The group is emitted in the same cycle, no ERR, then idx=0 and go IDLE.
- Undefined:
  - ERR pulse and partial group discarded.
  - No `VALID_OUT`, idx=0, go IDLE.

## Test plan
All scenarios use LANES=4 and BITS=8.
1. Reset mid-packet: after STP,11 assert RESET 2 cycles → all outputs 0; then STP,11,22,END yields normal emit, no ERR.
2. STP,11,22,END with DK 0,1,1,0 → single `VALID_OUT`, `LANE_OUT`=32'hfd2211fb, `DK_OUT`=4'b0110.
3. SDP,01..06,EDB contiguous → two consecutive `VALID_OUT` pulses, groups 32'h0302015c then 32'hfe060504, `DK_OUT` 4'b1110 then 4'b0111.
4. STP,AA,END:
   - With `BYTE_STRIPE_PAD_EN` → `LANE_OUT`=32'hfd7caafb, `DK_OUT`=4'b0010, no ERR.
   - Without it → ERR pulse, no `VALID_OUT`, then FSM IDLE.
5. Violations:
   - DK=1 byte 33 in IDLE → ERR, no `VALID_OUT`.
   - STP,11,STP,22,33,END → one ERR at the second STP, then group 32'hfd3322fb.
6. Gaps: case 2 with `VALID_IN` low for 3 cycles between each symbol → identical group and single `VALID_OUT`, no ERR.
